toggle_activity_monitor: RTL
============================

Name: toggle_activity_monitor

Overview:
Switching-activity monitor placed directly downstream of traffic_light_controller. It samples the controller's four 3-bit light outputs, concatenated into a 12-bit vector, and counts per-bit toggles over a fixed window of enabled cycles. At each window end it snapshots the counts and a total, then streams the per-bit counts out over a valid/ready handshake to the power-estimation datapath.

Parameters:
SIG_W, 12, monitored bit count; default concatenation is {light_M1, light_S, light_MT, light_M2}, MSB first.
CNT_W, 16, per-bit toggle counter width.
WIN_LOG2, 8, window length = 2**WIN_LOG2 enabled cycles (256).
IDX_W, 4, index width, = clog2(SIG_W).
TOT_W, 20, total width, = CNT_W + IDX_W.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  count enable.
sig_in  input  SIG_W  monitored signals.
win_done  output  1  one-cycle pulse when a window snapshot is taken.
total_toggles  output  TOT_W  sum of toggles in the last snapshot; held until the next snapshot.
out_valid  output  1  per-bit count beat valid.
out_ready  input  1  consumer ready.
out_idx  output  IDX_W  bit index of the current beat.
out_count  output  CNT_W  toggle count for out_idx.
out_last  output  1  high on the beat with out_idx = SIG_W-1.
overrun  output  1  sticky; a window ended while the previous drain was still in progress.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, including total_toggles and overrun. prev, primed, live counters, window counter and shadow bank are cleared; FSM goes to IDLE. Reset mid-drain aborts the drain with no further beats.
- Sampling:
  - prev <= sig_in every cycle, regardless of en.
  - primed <= en.
  - tog = (sig_in ^ prev) when en & primed, else 0.
  - The first enabled cycle after reset or after an en=0 gap counts no toggles.
- Live counters: one per bit, +1 per toggle, saturating at 2**CNT_W-1 (no wrap). A live total accumulates popcount(tog), saturating at 2**TOT_W-1.
- Window counter:
  - Increments only on en=1 cycles and freezes while en=0.
  - Terminal cycle is count = 2**WIN_LOG2-1, after which it wraps to 0.
- Window end (edge closing the terminal cycle):
  - snapshot = live + this cycle's tog.
  - Live counters and live total clear to 0.
  - Next cycle: win_done=1 for one cycle, and total_toggles is updated.
- FSM:
  - IDLE: out_valid=0. On window end, load the shadow bank, set idx=0, go to DRAIN.
  - DRAIN: out_valid=1; out_count=shadow[idx]; out_last=(idx==SIG_W-1).
  - On out_valid & out_ready: if last, go to IDLE, else idx+1.
  - While out_ready=0, out_idx and out_count stay stable.
- Overrun: if a window ends while in DRAIN, set overrun=1. The shadow bank and total_toggles keep their old values and the drain continues. Live counters still clear and win_done still pulses. overrun clears only on reset.
- Latency: window-end edge to first beat (out_valid=1, idx 0) is 1 cycle. Minimum drain is SIG_W cycles.

Decomposition:
- Package act_mon_pkg holds:
  - FSM state enum {ST_IDLE, ST_DRAIN};
  - default widths SIG_W, CNT_W, WIN_LOG2, IDX_W, TOT_W.
- Sub-module toggle_bit_counter: a single saturating CNT_W counter with inc and sync clear, instantiated SIG_W times with generate.
- Total adder, window counter and FSM live in the top module.

Test Plan:
1. Reset: hold rst=0 with random sig_in -> all outputs 0 and out_valid=0. Release rst, en=1, sig_in constant -> after 256 cycles win_done pulses, total_toggles=0, drain shows 12 beats with count 0 each.
2. sig_in[0] toggles every cycle, other bits constant, en=1 from reset, out_ready=1:
   - first window: out_count at idx 0 = 255, total_toggles=255;
   - second window: 256;
   - out_last only at idx 11.
3. Backpressure: during drain, drop out_ready for 3 cycles at idx 5 -> out_idx=5 and out_count stable for those 3 cycles; resumes at idx 6 with no beat lost or duplicated.
4. Overrun: out_ready=0 through two full windows (first window 255 toggles, second 256 toggles) -> overrun=1 after the second win_done. Drain still delivers the first window's values (idx0=255), and total_toggles stays 255.
5. en gap: toggle bit 3 every cycle and drop en for 10 cycles mid-window -> those 10 cycles plus the first re-enabled cycle add no counts, and the window end is delayed by 10 cycles.
6. Reset mid-drain: assert rst at beat idx 4 -> out_valid=0 asynchronously; after release, no beats appear until the next window end.

Source files
------------

// File: rtl/act_mon_pkg.sv
// Shared widths and FSM state type for the toggle activity monitor.
package act_mon_pkg;

  localparam int unsigned SIG_W    = 12;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned WIN_LOG2 = 8;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned TOT_W    = 20;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } mon_state_e;

endpackage

// File: rtl/toggle_bit_counter.sv
// Saturating per-bit toggle counter with synchronous clear.
module toggle_bit_counter #(
  parameter int unsigned CNT_W = act_mon_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count_next
);

  logic [CNT_W-1:0] count;

  // Exposes the post-increment value so a window snapshot can include this cycle's toggle.
  assign count_next = (inc && (count != '1)) ? count + CNT_W'(1) : count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Per-bit toggle counting over fixed windows of enabled cycles, drained as
// valid/ready beats of (index, count) after each window snapshot.
module toggle_activity_monitor #(
  parameter int unsigned SIG_W    = act_mon_pkg::SIG_W,
  parameter int unsigned CNT_W    = act_mon_pkg::CNT_W,
  parameter int unsigned WIN_LOG2 = act_mon_pkg::WIN_LOG2,
  parameter int unsigned IDX_W    = act_mon_pkg::IDX_W,
  parameter int unsigned TOT_W    = act_mon_pkg::TOT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SIG_W-1:0] sig_in,
  output logic             win_done,
  output logic [TOT_W-1:0] total_toggles,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             overrun
);

  import act_mon_pkg::*;

  logic [SIG_W-1:0]    prev;
  logic                primed;
  logic [SIG_W-1:0]    tog;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                win_end;
  logic [TOT_W-1:0]    live_tot;
  logic [TOT_W:0]      tot_sum;
  logic [TOT_W-1:0]    tot_nxt;
  logic [CNT_W-1:0]    live_nxt [SIG_W];
  logic [CNT_W-1:0]    shadow   [SIG_W];
  logic [IDX_W-1:0]    nxt_idx;
  mon_state_e          state;

  assign tog     = (en && primed) ? (sig_in ^ prev) : '0;
  assign win_end = en && (win_cnt == '1);
  assign nxt_idx = out_idx + IDX_W'(1);

  always_comb begin
    tot_sum = {1'b0, live_tot};
    for (int unsigned i = 0; i < SIG_W; i++) begin
      tot_sum = tot_sum + (TOT_W+1)'(tog[i]);
    end
    tot_nxt = tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
  end

  for (genvar g = 0; g < SIG_W; g++) begin : g_bit
    toggle_bit_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc        (tog[g]),
      .clr        (win_end),
      .count_next (live_nxt[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      primed   <= 1'b0;
      win_cnt  <= '0;
      live_tot <= '0;
    end else begin
      prev     <= sig_in;
      primed   <= en;
      if (en) win_cnt <= win_cnt + WIN_LOG2'(1);
      live_tot <= win_end ? '0 : tot_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      win_done      <= 1'b0;
      total_toggles <= '0;
      out_valid     <= 1'b0;
      out_idx       <= '0;
      out_count     <= '0;
      out_last      <= 1'b0;
      overrun       <= 1'b0;
      for (int unsigned i = 0; i < SIG_W; i++) shadow[i] <= '0;
    end else begin
      win_done <= win_end;
      case (state)
        ST_IDLE: begin
          if (win_end) begin
            for (int unsigned i = 0; i < SIG_W; i++) shadow[i] <= live_nxt[i];
            total_toggles <= tot_nxt;
            state         <= ST_DRAIN;
            out_valid     <= 1'b1;
            out_idx       <= '0;
            out_count     <= live_nxt[0];
            out_last      <= (SIG_W == 1);
          end
        end
        ST_DRAIN: begin
          // A window closing mid-drain is dropped; the bank being streamed stays intact.
          if (win_end) overrun <= 1'b1;
          if (out_ready) begin
            if (out_last) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_idx   <= '0;
              out_count <= '0;
              out_last  <= 1'b0;
            end else begin
              out_idx   <= nxt_idx;
              out_count <= shadow[nxt_idx];
              out_last  <= (nxt_idx == IDX_W'(SIG_W - 1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
